reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
//
// PURPOSE
// Next-generation register bank: DEPTH x DATA_WIDTH storage with one write port
// and NUM_RD independent read ports. Adds per-lane write strobes, a post-reset
// initialisation sweep that loads RESET_VAL into every entry, and a sticky
// error flag for illegal accesses. Unidirectional buses replace the shared
// tristate data bus; it sits behind the same top-level stimulus and control logic.
//
// PARAMETERS
// ADDR_WIDTH  4                  address bits per port
// DATA_WIDTH  8                  word width; must be a multiple of LANE_WIDTH
// LANE_WIDTH  4                  bits covered by one wr_strb bit
// DEPTH       1<<ADDR_WIDTH      number of entries (<= 2**ADDR_WIDTH)
// NUM_RD      2                  number of read ports (>=1)
// SYNC_READ   1                  1 = registered read (1-cycle), 0 = combinational
// RESET_VAL   {DATA_WIDTH{1'b0}} value written to every entry by the init sweep
//
// PORTS
// clk      in   1                          clock, all logic on posedge
// rst      in   1                          synchronous reset, active-high
// wr_en    in   1                          write request
// wr_addr  in   ADDR_WIDTH                 write address
// wr_data  in   DATA_WIDTH                 write data
// wr_strb  in   DATA_WIDTH/LANE_WIDTH      lane enables; bit i -> data[i*LANE_WIDTH +: LANE_WIDTH]
// rd_en    in   NUM_RD                     per-port read request
// rd_addr  in   NUM_RD*ADDR_WIDTH          port p address at [p*ADDR_WIDTH +: ADDR_WIDTH]
// rd_data  out  NUM_RD*DATA_WIDTH          port p data at [p*DATA_WIDTH +: DATA_WIDTH]
// rd_valid out  NUM_RD                     port p rd_data is valid
// busy     out  1                          init sweep in progress; accesses refused
// err      out  1                          sticky illegal-access flag
// err_clr  in   1                          clears err
//
// BEHAVIOUR
// - Clock clk, reset rst: single clock, synchronous active-high reset.
// - FSM states: SWEEP, READY. rst=1 -> SWEEP, ptr=0, busy=1, err=0,
//   rd_valid=0, rd_data=0 (registered mode). Storage is not cleared by rst itself.
// - SWEEP (rst=0): each cycle mem[ptr]<=RESET_VAL, ptr++. After writing
//   ptr==DEPTH-1 -> READY, busy=0. busy is high exactly DEPTH cycles after rst falls.
// - rst reasserted mid-sweep or in READY: restart at ptr=0.
// - Write (READY, wr_en=1, wr_addr<DEPTH): lanes with wr_strb[i]=1 updated at
//   posedge; other lanes keep their value. wr_strb=0 is a legal no-op.
// - Read, SYNC_READ=1: rd_en[p] in cycle N -> rd_data/rd_valid[p] in N+1.
//   Same-address write in N is write-first: the returned data is the
//   strobe-merged new word. Without rd_en, rd_valid=0 and rd_data holds.
// - Read, SYNC_READ=0: rd_data[p]=mem[rd_addr[p]], rd_valid[p]=rd_en[p]&~busy,
//   combinational; a same-cycle write is visible from the next cycle.
// - All read ports are independent; identical addresses on several ports are legal.
// - Illegal access sets err on the next posedge:
//   (a) wr_en or any rd_en while busy: write dropped, no rd_valid;
//   (b) address >= DEPTH: write dropped; read gives rd_valid=1, rd_data=0.
// - err is sticky until err_clr=1. A set in the same cycle wins over clear.
//
// TESTING
// 1 rst 1 cycle, DEPTH=16, RESET_VAL=8'hA5 -> busy=1 for 16 cycles; afterwards
//   a read of every address returns 8'hA5 with rd_valid one cycle later.
// 2 write addr 3, data 8'h3C, strb 2'b01, after a sweep -> read addr 3 = 8'hAC.
// 3 same cycle: write addr 5 = 8'h77 (strb 11) and port0 rd addr 5 -> next
//   cycle rd_data0=8'h77; port1 rd addr 6 in parallel = 8'hA5.
// 4 wr_en during sweep cycle 4 -> err=1, no write; err_clr next cycle -> err=0;
//   err_clr with a new illegal access in the same cycle -> err stays 1.
// 5 DEPTH=12: rd addr 14 -> rd_valid=1, rd_data=0, err=1; write addr 13 dropped.
// 6 rst at sweep cycle 7 -> ptr restarts; busy stays high 16 more cycles;
//   SYNC_READ=0 rerun of tests 2 and 3 gives the same values with 0-cycle latency.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: DEPTH x DATA_WIDTH register bank with one write port and
// NUM_RD independent read ports.
//
// After reset the bank runs an initialisation sweep that writes RESET_VAL
// into every entry, one entry per cycle. The sweep takes DEPTH cycles, and
// busy stays high for all of it. While busy is high, the bank refuses every
// access.
//
// Writes carry per-lane strobes. Each wr_strb bit covers LANE_WIDTH data bits.
//
// Reads are registered (SYNC_READ=1) or combinational (SYNC_READ=0). A
// registered read of the address being written in the same cycle returns the
// strobe-merged new word.
//
// Illegal accesses raise a sticky err flag. An access is illegal if it
// arrives while busy, or if its address is >= DEPTH. err_clr clears the flag.
// A new illegal access in the same cycle as err_clr keeps the flag set.
//
// Ports
//   clk       clock, everything on posedge
//   rst       synchronous reset, active-high
//   wr_en     write request
//   wr_addr   write address
//   wr_data   write data
//   wr_strb   lane enables, bit i -> wr_data[i*LANE_WIDTH +: LANE_WIDTH]
//   rd_en     per-port read request
//   rd_addr   port p address at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data   port p data at [p*DATA_WIDTH +: DATA_WIDTH]
//   rd_valid  port p data valid
//   busy      initialisation sweep in progress
//   err       sticky illegal-access flag
//   err_clr   clears err
module reg_file_mp #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    LANE_WIDTH = 4,
  parameter int                    DEPTH      = 1 << ADDR_WIDTH,
  parameter int                    NUM_RD     = 2,
  parameter int                    SYNC_READ  = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wr_strb,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  output logic                         busy,
  output logic                         err,
  input  logic                         err_clr
);

  localparam int                    NUM_LANES = DATA_WIDTH / LANE_WIDTH;
  // One extra bit so that DEPTH == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {SWEEP, READY} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   ptr, ptr_nxt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_addr_ok;
  logic                    wr_fire;
  logic [DATA_WIDTH-1:0]   wr_merged;
  logic [NUM_RD-1:0]       rd_bad;
  logic                    illegal;

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, regardless of block ordering in simulation.
    if (rst) begin
      state <= SWEEP;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch
    // is inferred.
    state_nxt = state;
    ptr_nxt   = ptr;
    if (state == SWEEP) begin
      ptr_nxt = ptr + 1'b1;
      if (ptr == LAST_PTR) begin
        state_nxt = READY;
        ptr_nxt   = '0;
      end
    end
  end

  assign busy = (state == SWEEP);

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  assign wr_addr_ok = ({1'b0, wr_addr} < DEPTH_W);
  assign wr_fire    = wr_en & ~busy & wr_addr_ok;

  // Lanes without a strobe keep the stored value.
  always_comb begin
    wr_merged = mem[wr_addr];
    for (int i = 0; i < NUM_LANES; i++) begin
      if (wr_strb[i]) wr_merged[i*LANE_WIDTH +: LANE_WIDTH] = wr_data[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  // NOTE: storage is deliberately not reset. The sweep initialises it, so the
  // array maps onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy)         mem[ptr]     <= RESET_VAL;
      else if (wr_fire) mem[wr_addr] <= wr_merged;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic                  addr_ok;
    logic [DATA_WIDTH-1:0] word;

    assign addr    = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign addr_ok = ({1'b0, addr} < DEPTH_W);
    // Out-of-range reads return zero rather than whatever the array decodes to.
    assign word    = addr_ok ? mem[addr] : '0;

    if (SYNC_READ != 0) begin : g_sync
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else if (rd_en[p] && !busy) begin
          valid_q <= 1'b1;
          // Write-first: a same-cycle write to this address is forwarded.
          data_q  <= (wr_fire && wr_addr == addr) ? wr_merged : word;
        end else begin
          valid_q <= 1'b0;
        end
      end

      assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data_q;
      assign rd_valid[p]                         = valid_q;
    end else begin : g_comb
      assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = word;
      assign rd_valid[p]                         = rd_en[p] & ~busy;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flag
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_bad = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_bad[p] = rd_en[p] & ({1'b0, rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]} >= DEPTH_W);
    end
  end

  assign illegal = busy ? (wr_en | (|rd_en))
                        : ((wr_en & ~wr_addr_ok) | (|rd_bad));

  always_ff @(posedge clk) begin
    if (rst)          err <= 1'b0;
    else if (illegal) err <= 1'b1;   // a new violation beats a clear
    else if (err_clr) err <= 1'b0;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp.
//
// Three instances share one stimulus:
//   [0] DEPTH=16, registered read
//   [1] DEPTH=12, registered read
//   [2] DEPTH=16, combinational read
// All three use RESET_VAL=8'hA5.
//
// A behavioural model (arrays plus a sweep countdown) predicts each
// instance's outputs.
module tb_reg_file_mp;

  localparam int         NI = 3;
  localparam int         NR = 2;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       rst, wr_en, err_clr;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] wr_strb, rd_en;
  logic [7:0] rd_addr;

  logic [15:0] rdd [NI];
  logic [1:0]  rdv [NI];
  logic        bsy [NI];
  logic        erf [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LANE_WIDTH(4), .DEPTH(16), .NUM_RD(2),
                .SYNC_READ(1), .RESET_VAL(8'hA5)) u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[0]),
    .rd_valid(rdv[0]), .busy(bsy[0]), .err(erf[0]), .err_clr(err_clr));

  reg_file_mp #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LANE_WIDTH(4), .DEPTH(12), .NUM_RD(2),
                .SYNC_READ(1), .RESET_VAL(8'hA5)) u_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[1]),
    .rd_valid(rdv[1]), .busy(bsy[1]), .err(erf[1]), .err_clr(err_clr));

  reg_file_mp #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LANE_WIDTH(4), .DEPTH(16), .NUM_RD(2),
                .SYNC_READ(0), .RESET_VAL(8'hA5)) u_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[2]),
    .rd_valid(rdv[2]), .busy(bsy[2]), .err(erf[2]), .err_clr(err_clr));

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int         dep      [NI];
  bit         sync_rd  [NI];
  logic [7:0] m_mem    [NI][16];
  int         m_left   [NI];      // sweep cycles still to run; 0 = ready
  bit         m_err    [NI];
  logic [7:0] m_rdata  [NI][NR];
  bit         m_rvalid [NI][NR];
  bit         m_init   [NI];      // storage fully defined

  function automatic logic [7:0] merge(logic [7:0] old, logic [7:0] nw, logic [1:0] s);
    return {s[1] ? nw[7:4] : old[7:4], s[0] ? nw[3:0] : old[3:0]};
  endfunction

  // Advance the model by one clock edge, using the inputs as they stand now.
  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      bit         m_busy;
      bit         bad;
      bit         wr_ok;
      int         a;
      logic [7:0] nw;
      if (rst) begin
        m_left[i] = dep[i];
        m_err[i]  = 1'b0;
        for (int p = 0; p < NR; p++) begin
          m_rvalid[i][p] = 1'b0;
          m_rdata[i][p]  = 8'h00;
        end
      end else begin
        m_busy = (m_left[i] > 0);
        bad    = m_busy && (wr_en || rd_en != 2'b00);
        if (!m_busy && wr_en && int'(wr_addr) >= dep[i]) bad = 1'b1;
        wr_ok = wr_en && !m_busy && int'(wr_addr) < dep[i];
        nw    = wr_ok ? merge(m_mem[i][wr_addr], wr_data, wr_strb) : 8'h00;
        for (int p = 0; p < NR; p++) begin
          a = int'(rd_addr[p*4 +: 4]);
          if (rd_en[p] && !m_busy) begin
            m_rvalid[i][p] = 1'b1;
            if (a >= dep[i]) begin
              bad           = 1'b1;
              m_rdata[i][p] = 8'h00;
            end else if (wr_ok && int'(wr_addr) == a) begin
              m_rdata[i][p] = nw;
            end else begin
              m_rdata[i][p] = m_mem[i][a];
            end
          end else begin
            m_rvalid[i][p] = 1'b0;
          end
        end
        if (m_busy) begin
          m_mem[i][dep[i] - m_left[i]] = RV;
          m_left[i]--;
          if (m_left[i] == 0) m_init[i] = 1'b1;
        end else if (wr_ok) begin
          m_mem[i][wr_addr] = nw;
        end
        if (bad)          m_err[i] = 1'b1;
        else if (err_clr) m_err[i] = 1'b0;
      end
    end
  endtask

  // Apply one clock edge. Outputs are sampled 1 ns after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; rd_en = 2'b00; err_clr = 1'b0;
  endtask

  // Count the observations of busy, from right after reset until it drops.
  task automatic count_busy(output int na, output int nb);
    na = 0;
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      if (bsy[0] === 1'b1) na++;
      if (bsy[1] === 1'b1) nb++;
      if (bsy[0] !== 1'b1 && bsy[1] !== 1'b1) break;
      step();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int na, nb;
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bsy[0] !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", bsy[0]); end
    checks++; if (erf[0] !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", erf[0]); end
    checks++; if (rdv[0] !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b want 00", rdv[0]); end
    checks++; if (rdd[0] !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", rdd[0]); end
    count_busy(na, nb);
    checks++; if (na != 16) begin errors++; $display("FAIL sweep_len16: got %0d want 16", na); end
    checks++; if (nb != 12) begin errors++; $display("FAIL sweep_len12: got %0d want 12", nb); end
    for (int a = 0; a < 16; a++) begin
      rd_en   = 2'b11;
      rd_addr = {4'(15 - a), 4'(a)};
      step();
      checks++; if (rdv[0] !== 2'b11) begin errors++; $display("FAIL sweep_valid[%0d]: got %b want 11", a, rdv[0]); end
      checks++; if (rdd[0] !== {RV, RV}) begin errors++; $display("FAIL sweep_data[%0d]: got %h want a5a5", a, rdd[0]); end
    end
    idle();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic test_strobe();
    idle();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h3C; wr_strb = 2'b01;
    step();
    wr_en = 1'b0;
    rd_en = 2'b01; rd_addr = 8'h03;
    #1;
    checks++; if (rdv[2][0] !== 1'b1) begin errors++; $display("FAIL strobe_async_valid: got %b want 1", rdv[2][0]); end
    checks++; if (rdd[2][7:0] !== 8'hAC) begin errors++; $display("FAIL strobe_async_data: got %h want ac", rdd[2][7:0]); end
    step();
    checks++; if (rdv[0][0] !== 1'b1) begin errors++; $display("FAIL strobe_valid: got %b want 1", rdv[0][0]); end
    checks++; if (rdd[0][7:0] !== 8'hAC) begin errors++; $display("FAIL strobe_data: got %h want ac", rdd[0][7:0]); end
    idle();
  endtask

  task automatic test_write_first();
    idle();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h77; wr_strb = 2'b11;
    rd_en = 2'b11; rd_addr = 8'h65;
    #1;
    checks++; if (rdd[2] !== {RV, RV}) begin errors++; $display("FAIL wf_async_before: got %h want a5a5", rdd[2]); end
    step();
    wr_en = 1'b0;
    checks++; if (rdv[0] !== 2'b11) begin errors++; $display("FAIL wf_valid: got %b want 11", rdv[0]); end
    checks++; if (rdd[0] !== 16'hA577) begin errors++; $display("FAIL wf_data: got %h want a577", rdd[0]); end
    #1;
    checks++; if (rdd[2] !== 16'hA577) begin errors++; $display("FAIL wf_async_after: got %h want a577", rdd[2]); end
    rd_en = 2'b00;
    step();
    checks++; if (rdv[0] !== 2'b00) begin errors++; $display("FAIL wf_idle_valid: got %b want 00", rdv[0]); end
    checks++; if (rdd[0] !== 16'hA577) begin errors++; $display("FAIL wf_hold: got %h want a577", rdd[0]); end
  endtask

  task automatic test_err_busy();
    int na, nb;
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF; wr_strb = 2'b11;
    step();
    wr_en = 1'b0;
    checks++; if (erf[0] !== 1'b1) begin errors++; $display("FAIL busy_wr_err: got %b want 1", erf[0]); end
    err_clr = 1'b1;
    step();
    checks++; if (erf[0] !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", erf[0]); end
    rd_en = 2'b01; rd_addr = 8'h00;
    step();
    rd_en = 2'b00;
    checks++; if (erf[0] !== 1'b1) begin errors++; $display("FAIL set_beats_clr: got %b want 1", erf[0]); end
    checks++; if (rdv[0][0] !== 1'b0) begin errors++; $display("FAIL busy_rd_valid: got %b want 0", rdv[0][0]); end
    step();
    err_clr = 1'b0;
    count_busy(na, nb);
    checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL err_sweep_done: got %b want 0", bsy[0]); end
    rd_en = 2'b01; rd_addr = 8'h00;
    step();
    checks++; if (rdd[0][7:0] !== RV) begin errors++; $display("FAIL busy_wr_dropped: got %h want a5", rdd[0][7:0]); end
    idle();
  endtask

  task automatic test_out_of_range();
    idle();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (erf[1] !== 1'b0) begin errors++; $display("FAIL oor_pre_err: got %b want 0", erf[1]); end
    rd_en = 2'b01; rd_addr = 8'h0E;
    step();
    rd_en = 2'b00;
    checks++; if (rdv[1][0] !== 1'b1) begin errors++; $display("FAIL oor_rd_valid: got %b want 1", rdv[1][0]); end
    checks++; if (rdd[1][7:0] !== 8'h00) begin errors++; $display("FAIL oor_rd_data: got %h want 00", rdd[1][7:0]); end
    checks++; if (erf[1] !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b want 1", erf[1]); end
    checks++; if (erf[0] !== 1'b0) begin errors++; $display("FAIL inrange_rd_err: got %b want 0", erf[0]); end
    checks++; if (rdd[0][7:0] !== RV) begin errors++; $display("FAIL inrange_rd_data: got %h want a5", rdd[0][7:0]); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd13; wr_data = 8'h11; wr_strb = 2'b11;
    step();
    wr_en = 1'b0;
    checks++; if (erf[1] !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b want 1", erf[1]); end
    checks++; if (erf[0] !== 1'b0) begin errors++; $display("FAIL inrange_wr_err: got %b want 0", erf[0]); end
    rd_en = 2'b01; rd_addr = 8'h0D;
    step();
    rd_en = 2'b00;
    checks++; if (rdd[0][7:0] !== 8'h11) begin errors++; $display("FAIL inrange_wr_data: got %h want 11", rdd[0][7:0]); end
    checks++; if (rdd[1][7:0] !== 8'h00) begin errors++; $display("FAIL oor_wr_dropped: got %h want 00", rdd[1][7:0]); end
    idle();
  endtask

  task automatic test_rst_mid_sweep();
    int na, nb;
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (7) step();
    checks++; if (bsy[0] !== 1'b1) begin errors++; $display("FAIL mid_sweep_busy: got %b want 1", bsy[0]); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(na, nb);
    checks++; if (na != 16) begin errors++; $display("FAIL restart_len: got %0d want 16", na); end
    test_strobe();
    test_write_first();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 99) == 0);
      wr_en   = $urandom_range(0, 1) == 1;
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 8'($urandom);
      wr_strb = 2'($urandom_range(0, 3));
      rd_en   = 2'($urandom_range(0, 3));
      rd_addr = 8'($urandom);
      err_clr = ($urandom_range(0, 7) == 0);
      #1;
      for (int p = 0; p < NR; p++) begin
        checks++;
        if (rdv[2][p] !== (rd_en[p] && m_left[2] == 0)) begin
          errors++; $display("FAIL rand_async_valid[%0d] cyc %0d: got %b want %b", p, n, rdv[2][p], rd_en[p] && m_left[2] == 0);
        end
        if (m_init[2]) begin
          checks++;
          if (rdd[2][p*8 +: 8] !== m_mem[2][rd_addr[p*4 +: 4]]) begin
            errors++; $display("FAIL rand_async_data[%0d] cyc %0d: got %h want %h", p, n, rdd[2][p*8 +: 8], m_mem[2][rd_addr[p*4 +: 4]]);
          end
        end
      end
      step();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (bsy[i] !== (m_left[i] > 0)) begin errors++; $display("FAIL rand_busy[%0d] cyc %0d: got %b want %b", i, n, bsy[i], m_left[i] > 0); end
        checks++;
        if (erf[i] !== m_err[i]) begin errors++; $display("FAIL rand_err[%0d] cyc %0d: got %b want %b", i, n, erf[i], m_err[i]); end
        if (sync_rd[i]) begin
          for (int p = 0; p < NR; p++) begin
            checks++;
            if (rdv[i][p] !== m_rvalid[i][p]) begin
              errors++; $display("FAIL rand_valid[%0d][%0d] cyc %0d: got %b want %b", i, p, n, rdv[i][p], m_rvalid[i][p]);
            end
            checks++;
            if (rdd[i][p*8 +: 8] !== m_rdata[i][p]) begin
              errors++; $display("FAIL rand_data[%0d][%0d] cyc %0d: got %h want %h", i, p, n, rdd[i][p*8 +: 8], m_rdata[i][p]);
            end
          end
        end
      end
    end
    idle();
  endtask

  initial begin
    dep[0] = 16; dep[1] = 12; dep[2] = 16;
    sync_rd[0] = 1'b1; sync_rd[1] = 1'b1; sync_rd[2] = 1'b0;
    for (int i = 0; i < NI; i++) begin
      m_left[i] = 0;
      m_err[i]  = 1'b0;
      m_init[i] = 1'b0;
    end
    rst = 1'b1; wr_en = 1'b0; err_clr = 1'b0; rd_en = 2'b00;
    wr_addr = '0; wr_data = '0; wr_strb = '0; rd_addr = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_strobe();
    test_write_first();
    test_err_busy();
    test_out_of_range();
    test_rst_mid_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
